// File: rtl/rule_arb_pkg.sv
// Shared defaults and FSM state type for the packet-atomic rule stream arbiter.
package rule_arb_pkg;

  localparam int DEF_NUM_IN  = 4;
  localparam int DEF_DATA_W  = 128;
  localparam int DEF_EMPTY_W = 4;
  localparam int DEF_SRC_W   = $clog2(DEF_NUM_IN);

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first requester after 'last', wrapping modulo NUM_IN.
module rr_pick #(
  parameter int NUM_IN = 4,
  parameter int SRC_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SRC_W-1:0]  last,
  output logic [SRC_W-1:0]  gnt_idx,
  output logic              gnt_any
);

  // Walk from lowest to highest priority so the nearest requester after 'last' wins.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = NUM_IN; k >= 1; k--) begin
      if (req[SRC_W'((int'(last) + k) % NUM_IN)]) begin
        gnt_idx = SRC_W'((int'(last) + k) % NUM_IN);
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rule_stream_arb.sv
// Packet-atomic round-robin merge of NUM_IN rule-match streams onto one registered
// ready/valid stream; the grant is held from the first beat until eop.
module rule_stream_arb
  import rule_arb_pkg::*;
#(
  parameter  int NUM_IN  = DEF_NUM_IN,
  parameter  int DATA_W  = DEF_DATA_W,
  parameter  int EMPTY_W = DEF_EMPTY_W,
  localparam int SRC_W   = $clog2(NUM_IN)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_IN-1:0]         in_sop,
  input  logic [NUM_IN-1:0]         in_eop,
  input  logic [NUM_IN*EMPTY_W-1:0] in_empty,
  input  logic [NUM_IN-1:0]         in_valid,
  input  logic [NUM_IN*DATA_W-1:0]  in_data,
  output logic [NUM_IN-1:0]         in_ready,
  output logic                      out_sop,
  output logic                      out_eop,
  output logic [EMPTY_W-1:0]        out_empty,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [SRC_W-1:0]          out_src,
  input  logic                      out_ready,
  output logic                      err_proto,
  output arb_state_t                dbg_state
);

  // Handshake: a beat moves on a port in every cycle where valid and ready are both
  // high at the rising edge; out_* never change while out_valid is high and
  // out_ready is low.

  arb_state_t         state, state_nxt;
  logic [SRC_W-1:0]   cur, cur_nxt;
  logic [SRC_W-1:0]   last, last_nxt;
  logic               first_beat, first_beat_nxt;
  logic [SRC_W-1:0]   pick_idx;
  logic               pick_any;
  logic               slot_free;
  logic               accept;
  logic               frame_bad;

  logic [DATA_W-1:0]  data_arr  [NUM_IN];
  logic [EMPTY_W-1:0] empty_arr [NUM_IN];

  for (genvar g = 0; g < NUM_IN; g++) begin : g_unpack
    assign data_arr[g]  = in_data[g*DATA_W +: DATA_W];
    assign empty_arr[g] = in_empty[g*EMPTY_W +: EMPTY_W];
  end

  assign slot_free = !out_valid || out_ready;
  assign dbg_state = state;

  rr_pick #(
    .NUM_IN (NUM_IN),
    .SRC_W  (SRC_W)
  ) u_pick (
    .req     (in_valid),
    .last    (last),
    .gnt_idx (pick_idx),
    .gnt_any (pick_any)
  );

  // Only the very first beat of a grant may carry sop.
  assign frame_bad = first_beat ? !in_sop[cur] : in_sop[cur];

  always_comb begin
    state_nxt      = state;
    cur_nxt        = cur;
    last_nxt       = last;
    first_beat_nxt = first_beat;
    in_ready       = '0;
    accept         = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          cur_nxt        = pick_idx;
          first_beat_nxt = 1'b1;
          state_nxt      = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        in_ready = slot_free ? (NUM_IN'(1) << cur) : '0;
        accept   = slot_free && in_valid[cur];
        if (accept) begin
          first_beat_nxt = 1'b0;
          if (in_eop[cur]) begin
            last_nxt  = cur;
            state_nxt = ARB_IDLE;
          end
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      cur        <= '0;
      last       <= SRC_W'(NUM_IN - 1);
      first_beat <= 1'b0;
    end else begin
      state      <= state_nxt;
      cur        <= cur_nxt;
      last       <= last_nxt;
      first_beat <= first_beat_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_empty <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      err_proto <= 1'b0;
    end else begin
      err_proto <= accept && frame_bad;
      if (accept) begin
        out_sop   <= in_sop[cur];
        out_eop   <= in_eop[cur];
        out_empty <= empty_arr[cur];
        out_data  <= data_arr[cur];
        out_src   <= cur;
        out_valid <= 1'b1;
      end else if (slot_free) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rule_stream_arb.sv
// Directed bench for rule_stream_arb: per-input beat queues, output scoreboard,
// and hand-derived ordering, latency, back-pressure, framing and reset checks.
module tb_rule_stream_arb;
  import rule_arb_pkg::*;

  localparam int NUM_IN  = DEF_NUM_IN;
  localparam int DATA_W  = DEF_DATA_W;
  localparam int EMPTY_W = DEF_EMPTY_W;
  localparam int SRC_W   = DEF_SRC_W;
  localparam int OBS_W   = 1 + SRC_W + 1 + 1 + EMPTY_W + DATA_W;

  typedef struct packed {
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
    logic [DATA_W-1:0]  data;
  } beat_t;

  // clock / reset
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_IN-1:0]         in_sop, in_eop, in_valid, in_ready;
  logic [NUM_IN*EMPTY_W-1:0] in_empty;
  logic [NUM_IN*DATA_W-1:0]  in_data;
  logic                      out_sop, out_eop, out_valid, out_ready, err_proto;
  logic [EMPTY_W-1:0]        out_empty;
  logic [DATA_W-1:0]         out_data;
  logic [SRC_W-1:0]          out_src;
  arb_state_t                dbg_state;

  rule_stream_arb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .in_empty  (in_empty),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_empty (out_empty),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .err_proto (err_proto),
    .dbg_state (dbg_state)
  );

  beat_t             src_q [NUM_IN][$];
  logic [OBS_W-1:0]  exp_q[$];
  beat_t             drv_b;
  logic [NUM_IN-1:0] fire;
  int                n_checks, n_pass;
  int                cyc, beat_cnt, err_cnt, gap_cnt;
  bit                check_gap, gap_armed;

  task automatic chk(input string tag, input logic [OBS_W-1:0] got,
                     input logic [OBS_W-1:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  function automatic logic [DATA_W-1:0] mk_data(input int s, input int p, input int b);
    return {32'(s), 32'(p), 32'(b), 32'hA5A5_5A5A};
  endfunction

  // mode 0: clean packet; 1: first beat lacks sop; 2: extra sop on beat 1.
  // Call order is the hand-expected output order.
  task automatic pkt(input int s, input int p, input int n, input int empty, input int mode);
    beat_t b;
    logic  err;
    for (int k = 0; k < n; k++) begin
      b.sop   = (mode == 1) ? 1'b0 : ((k == 0) || (mode == 2 && k == 1));
      b.eop   = (k == n - 1);
      b.empty = b.eop ? EMPTY_W'(empty) : '0;
      b.data  = mk_data(s, p, k);
      err     = (mode == 1 && k == 0) || (mode == 2 && k == 1);
      src_q[s].push_back(b);
      exp_q.push_back({err, SRC_W'(s), b.sop, b.eop, b.empty, b.data});
    end
  endtask

  // driver: pops beats that were handshaken at the previous edge, presents the next
  initial begin
    in_valid = '0; in_sop = '0; in_eop = '0; in_empty = '0; in_data = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int i = 0; i < NUM_IN; i++) begin
        if (fire[i] && rst_n && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          drv_b = src_q[i][0];
          in_valid[i] = 1'b1;
          in_sop[i]   = drv_b.sop;
          in_eop[i]   = drv_b.eop;
          in_empty[i*EMPTY_W +: EMPTY_W] = drv_b.empty;
          in_data[i*DATA_W +: DATA_W]    = drv_b.data;
        end else begin
          in_valid[i] = 1'b0;
          in_sop[i]   = 1'b0;
          in_eop[i]   = 1'b0;
          in_empty[i*EMPTY_W +: EMPTY_W] = '0;
          in_data[i*DATA_W +: DATA_W]    = '0;
        end
      end
    end
  end

  // monitor / scoreboard, sampled on the falling edge
  initial begin
    fire = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        fire = '0;
      end else begin
        fire = in_valid & in_ready;
        chk("in_ready_onehot", ($countones(in_ready) <= 1), 1);
        if (err_proto) err_cnt++;
        if (!out_valid) gap_cnt++;
        if (out_valid && out_ready) begin
          if (check_gap && out_sop) begin
            if (gap_armed) chk("idle_gap", gap_cnt, 1);
            gap_armed = 1'b1;
          end
          if (exp_q.size() == 0) chk("unexpected_beat", {err_proto, out_src, out_sop,
                                     out_eop, out_empty, out_data}, '0);
          else chk("beat", {err_proto, out_src, out_sop, out_eop, out_empty, out_data},
                   exp_q.pop_front());
          beat_cnt++;
        end
        if (out_valid) gap_cnt = 0;
      end
    end
  end

  task automatic at_drive();
    @(posedge clk);
    #2;
  endtask

  task automatic flush();
    for (int i = 0; i < NUM_IN; i++) src_q[i].delete();
    exp_q.delete();
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) at_drive();
    chk("drain_left", exp_q.size(), 0);
    at_drive();
  endtask

  task automatic do_reset();
    at_drive();
    rst_n = 1'b0;
    flush();
    repeat (2) at_drive();
    @(negedge clk);
    rst_n = 1'b1;
    at_drive();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t_in, b0, e0;
    rst_n = 1'b0; out_ready = 1'b0;
    n_checks = 0; n_pass = 0; beat_cnt = 0; err_cnt = 0; gap_cnt = 0;
    check_gap = 1'b0; gap_armed = 1'b0;
    repeat (3) at_drive();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sop",   out_sop, 0);
    chk("rst_out_eop",   out_eop, 0);
    chk("rst_out_empty", out_empty, 0);
    chk("rst_out_data",  out_data, 0);
    chk("rst_out_src",   out_src, 0);
    chk("rst_err",       err_proto, 0);
    chk("rst_in_ready",  in_ready, 0);
    chk("rst_state",     dbg_state, ARB_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    at_drive();
    out_ready = 1'b1;

    // 1: single 3-beat packet on in0, latency from in_valid to out_valid
    b0 = beat_cnt;
    t_in = cyc + 1;
    pkt(0, 1, 3, 5, 0);
    for (int k = 0; k < 20 && !out_valid; k++) at_drive();
    chk("t1_latency", cyc - t_in, 2);
    drain();
    chk("t1_nbeats", beat_cnt - b0, 3);

    // 2: all four inputs contend; round robin from in0 with one idle cycle between
    do_reset();
    check_gap = 1'b1; gap_armed = 1'b0;
    b0 = beat_cnt;
    pkt(0, 2, 2, 1, 0);
    pkt(1, 2, 2, 2, 0);
    pkt(2, 2, 2, 3, 0);
    pkt(3, 2, 2, 4, 0);
    pkt(0, 3, 2, 6, 0);
    drain();
    check_gap = 1'b0;
    chk("t2_nbeats", beat_cnt - b0, 10);

    // 3: back-pressure in the middle of an in1 packet
    b0 = beat_cnt;
    pkt(1, 3, 4, 2, 0);
    for (int k = 0; k < 20 && !out_valid; k++) at_drive();
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t3_hold_valid", out_valid, 1);
      chk("t3_hold_data",  out_data, mk_data(1, 3, 0));
      chk("t3_hold_ready", in_ready, 0);
    end
    at_drive();
    out_ready = 1'b1;
    drain();
    chk("t3_nbeats", beat_cnt - b0, 4);

    // 4: single-beat packets on in2 and in3 alternate
    for (int k = 0; k < 3; k++) begin
      pkt(2, 10 + k, 1, 9, 0);
      pkt(3, 10 + k, 1, 8, 0);
    end
    drain();

    // 5: framing violations still forward the beats and pulse err_proto once each
    e0 = err_cnt;
    pkt(0, 5, 2, 1, 1);
    pkt(0, 6, 3, 7, 2);
    drain();
    chk("t5_err_pulses", err_cnt - e0, 2);

    // 6: reset in the middle of an in1 packet, then in0 wins first
    pkt(1, 8, 4, 0, 0);
    for (int k = 0; k < 30 && !(out_valid && out_data == mk_data(1, 8, 1)); k++) at_drive();
    chk("t6_beat2", out_data, mk_data(1, 8, 1));
    rst_n = 1'b0;
    #1;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_out_sop",   out_sop, 0);
    chk("t6_out_eop",   out_eop, 0);
    chk("t6_out_data",  out_data, 0);
    chk("t6_out_src",   out_src, 0);
    chk("t6_in_ready",  in_ready, 0);
    chk("t6_state",     dbg_state, ARB_IDLE);
    flush();
    repeat (2) at_drive();
    @(negedge clk);
    rst_n = 1'b1;
    at_drive();
    pkt(0, 9, 1, 3, 0);
    pkt(1, 9, 1, 4, 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
